// File: rtl/dram_tag_check.sv
// Tag-check stage of the DRAM cache read path: joins a request descriptor with an R beat
// and presents one registered hit/miss/evict result. Optional counters: TAG_CHECK_STATS_EN.
module dram_tag_check #(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 0,
    parameter int unsigned DATA_W   = 72
`ifdef TAG_CHECK_STATS_EN
    ,parameter int unsigned COUNT_W = 32
`endif
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic                                  req_is_write_i,
    input  logic [ADDR_W-1:0]                     req_addr_i,
    input  logic                                  rvalid_i,
    output logic                                  rready_o,
    input  logic [DATA_W-1:0]                     rdata_i,
    input  logic [ADDR_W-INDEX_W-OFFSET_W-1:0]    rtag_i,
    input  logic                                  rmeta_valid_i,
    input  logic                                  rmeta_dirty_i,
    output logic                                  res_valid_o,
    input  logic                                  res_ready_i,
    output logic [1:0]                            res_class_o,
    output logic                                  res_evict_o,
    output logic [DATA_W-1:0]                     res_data_o,
    output logic [ADDR_W-1:0]                     res_addr_o
`ifdef TAG_CHECK_STATS_EN
    ,input  logic                                 stat_clr_i,
    output logic [COUNT_W-1:0]                    stat_rhit_o,
    output logic [COUNT_W-1:0]                    stat_rmiss_o,
    output logic [COUNT_W-1:0]                    stat_whit_o,
    output logic [COUNT_W-1:0]                    stat_wmiss_o,
    output logic [COUNT_W-1:0]                    stat_evict_o
`endif
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

    slot_e              state_q, state_d;
    logic [1:0]         class_q, class_d;
    logic               evict_q, evict_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;

    logic               slot_free_c;
    logic               fire_c;
    logic               hit_c;
    logic [1:0]         class_c;
    logic               evict_c;

    // Join: each side is only accepted together with the other.
    assign slot_free_c = (state_q == EMPTY) || res_ready_i;
    assign req_ready_o = rvalid_i && slot_free_c;
    assign rready_o    = req_valid_i && slot_free_c;
    assign fire_c      = req_valid_i && rvalid_i && slot_free_c;

    // An invalid line never hits, even when the stale tag matches.
    assign hit_c   = rmeta_valid_i && (req_addr_i[ADDR_W-1 -: TAG_W] == rtag_i);
    assign class_c = {req_is_write_i, !hit_c};
    assign evict_c = !hit_c && rmeta_valid_i && rmeta_dirty_i;

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        evict_d = evict_q;
        data_d  = data_q;
        addr_d  = addr_q;
        if (fire_c) begin
            state_d = FULL;
            class_d = class_c;
            evict_d = evict_c;
            data_d  = rdata_i;
            addr_d  = req_addr_i;
        end else if ((state_q == FULL) && res_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            class_q <= 2'b00;
            evict_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            evict_q <= evict_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign res_valid_o = (state_q == FULL);
    assign res_class_o = class_q;
    assign res_evict_o = evict_q;
    assign res_data_o  = data_q;
    assign res_addr_o  = addr_q;

`ifdef TAG_CHECK_STATS_EN
    // Counter slots 0..3 follow the class encoding; slot 4 counts evictions.
    logic [COUNT_W-1:0] cnt_q [5];
    logic [COUNT_W-1:0] cnt_d [5];
    logic [4:0]         inc_c;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inc_c[i] = fire_c && (class_c == 2'(i));
        end
        inc_c[4] = fire_c && evict_c;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stat_clr_i) begin
                cnt_d[i] = '0;
            end else if (inc_c[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign stat_rhit_o  = cnt_q[0];
    assign stat_rmiss_o = cnt_q[1];
    assign stat_whit_o  = cnt_q[2];
    assign stat_wmiss_o = cnt_q[3];
    assign stat_evict_o = cnt_q[4];
`endif

endmodule

// File: tb/tb_dram_tag_check.sv
// Directed bench for dram_tag_check; counter tests compile only with TAG_CHECK_STATS_EN.
module tb_dram_tag_check;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 72;
    localparam int unsigned TAG_W  = 56;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid_i, req_is_write_i, rvalid_i;
    logic               rmeta_valid_i, rmeta_dirty_i, res_ready_i;
    logic [ADDR_W-1:0]  req_addr_i;
    logic [DATA_W-1:0]  rdata_i;
    logic [TAG_W-1:0]   rtag_i;
    logic               req_ready_o, rready_o, res_valid_o, res_evict_o;
    logic [1:0]         res_class_o;
    logic [DATA_W-1:0]  res_data_o;
    logic [ADDR_W-1:0]  res_addr_o;
`ifdef TAG_CHECK_STATS_EN
    logic               stat_clr_i;
    logic [1:0]         stat_rhit_o, stat_rmiss_o, stat_whit_o, stat_wmiss_o, stat_evict_o;
`endif

    int passed = 0;
    int total  = 0;
    int fire_cnt = 0;

    localparam logic [63:0] ADDR_A  = 64'h0000_1234_5678_9A00;
    localparam logic [55:0] TAG_HIT = 56'h00_0012_3456_789A;
    localparam logic [55:0] TAG_MIS = 56'h00_0012_3456_7890;
    localparam logic [71:0] DATA_1  = 72'hA5_0123_4567_89AB_CDEF;
    localparam logic [71:0] DATA_2  = 72'h5A_FEDC_BA98_7654_3210;
    localparam logic [71:0] DATA_3  = 72'h3C_1111_2222_3333_4444;

    dram_tag_check #(
        .ADDR_W(64), .INDEX_W(8), .OFFSET_W(0), .DATA_W(72)
`ifdef TAG_CHECK_STATS_EN
        ,.COUNT_W(2)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_is_write_i(req_is_write_i), .req_addr_i(req_addr_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rtag_i(rtag_i),
        .rmeta_valid_i(rmeta_valid_i), .rmeta_dirty_i(rmeta_dirty_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_class_o(res_class_o), .res_evict_o(res_evict_o),
        .res_data_o(res_data_o), .res_addr_o(res_addr_o)
`ifdef TAG_CHECK_STATS_EN
        ,.stat_clr_i(stat_clr_i), .stat_rhit_o(stat_rhit_o), .stat_rmiss_o(stat_rmiss_o),
        .stat_whit_o(stat_whit_o), .stat_wmiss_o(stat_wmiss_o), .stat_evict_o(stat_evict_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && req_valid_i && rvalid_i && req_ready_o && rready_o) fire_cnt++;

    task automatic set_pair(input logic wr, input logic [63:0] a, input logic [55:0] t,
                            input logic mv, input logic md, input logic [71:0] d);
        req_valid_i = 1'b1; rvalid_i = 1'b1;
        req_is_write_i = wr; req_addr_i = a; rtag_i = t;
        rmeta_valid_i = mv; rmeta_dirty_i = md; rdata_i = d;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0; rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; res_ready_i = 1'b1; idle_inputs();
        req_is_write_i = 1'b0; req_addr_i = '0; rtag_i = '0;
        rmeta_valid_i = 1'b0; rmeta_dirty_i = 1'b0; rdata_i = '0;
`ifdef TAG_CHECK_STATS_EN
        stat_clr_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        total++;
        if (res_valid_o !== 1'b0 || res_class_o !== 2'd0 || res_evict_o !== 1'b0 ||
            res_data_o !== '0 || res_addr_o !== '0)
            $display("FAIL reset_state: valid=%b class=%0d evict=%b data=%h addr=%h, need all 0",
                     res_valid_o, res_class_o, res_evict_o, res_data_o, res_addr_o);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one pair at a negedge, checks readys, then checks the registered result.
    task automatic fire_and_check(input string name, input logic wr, input logic [55:0] t,
                                  input logic mv, input logic md, input logic [71:0] d,
                                  input logic [1:0] exp_cls, input logic exp_ev);
        res_ready_i = 1'b1;
        set_pair(wr, ADDR_A, t, mv, md, d);
        #1;
        total++;
        if (req_ready_o !== 1'b1 || rready_o !== 1'b1)
            $display("FAIL %s_readys: req_ready=%b rready=%b, need 1/1", name, req_ready_o, rready_o);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (res_valid_o !== 1'b1 || res_class_o !== exp_cls || res_evict_o !== exp_ev)
            $display("FAIL %s_result: valid=%b class=%0d evict=%b, need 1 %0d %b",
                     name, res_valid_o, res_class_o, res_evict_o, exp_cls, exp_ev);
        else passed++;
        total++;
        if (res_data_o !== d || res_addr_o !== ADDR_A)
            $display("FAIL %s_echo: data=%h addr=%h, need %h %h", name, res_data_o, res_addr_o, d, ADDR_A);
        else passed++;
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        total++;
        if (res_valid_o !== 1'b0)
            $display("FAIL %s_drain: valid=%b, need 0", name, res_valid_o);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_read_hit();
        fire_and_check("read_hit", 1'b0, TAG_HIT, 1'b1, 1'b0, DATA_1, 2'd0, 1'b0);
    endtask

    task automatic test_write_miss_evict();
        fire_and_check("write_miss", 1'b1, TAG_MIS, 1'b1, 1'b1, DATA_2, 2'd3, 1'b1);
    endtask

    task automatic test_invalid_line();
        fire_and_check("invalid_line", 1'b0, TAG_HIT, 1'b0, 1'b1, DATA_3, 2'd1, 1'b0);
    endtask

    task automatic test_backpressure();
        res_ready_i = 1'b0;
        set_pair(1'b1, ADDR_A, TAG_HIT, 1'b1, 1'b1, DATA_1);
        @(posedge clk); #1;
        total++;
        if (res_valid_o !== 1'b1 || res_class_o !== 2'd2 || res_evict_o !== 1'b0)
            $display("FAIL bp_first: valid=%b class=%0d evict=%b, need 1 2 0",
                     res_valid_o, res_class_o, res_evict_o);
        else passed++;
        @(negedge clk);
        set_pair(1'b0, ADDR_A, TAG_MIS, 1'b1, 1'b0, DATA_2);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (req_ready_o !== 1'b0 || rready_o !== 1'b0 || res_valid_o !== 1'b1 ||
                res_class_o !== 2'd2 || res_data_o !== DATA_1)
                $display("FAIL bp_hold%0d: req_ready=%b rready=%b valid=%b class=%0d data=%h, need 0 0 1 2 %h",
                         i, req_ready_o, rready_o, res_valid_o, res_class_o, res_data_o, DATA_1);
            else passed++;
            @(negedge clk);
        end
        res_ready_i = 1'b1;
        #1;
        total++;
        if (req_ready_o !== 1'b1 || rready_o !== 1'b1)
            $display("FAIL bp_release_readys: req_ready=%b rready=%b, need 1/1", req_ready_o, rready_o);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (res_valid_o !== 1'b1 || res_class_o !== 2'd1 || res_data_o !== DATA_2)
            $display("FAIL bp_replace: valid=%b class=%0d data=%h, need 1 1 %h",
                     res_valid_o, res_class_o, res_data_o, DATA_2);
        else passed++;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_one_side();
        int start;
        start = fire_cnt;
        res_ready_i = 1'b1;
        set_pair(1'b0, ADDR_A, TAG_HIT, 1'b1, 1'b0, DATA_3);
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (rready_o !== 1'b0 || res_valid_o !== 1'b0)
                $display("FAIL one_side%0d: rready=%b valid=%b, need 0 0", i, rready_o, res_valid_o);
            else passed++;
            @(negedge clk);
        end
        req_valid_i = 1'b1;
        #1;
        total++;
        if (rready_o !== 1'b1 || req_ready_o !== 1'b1)
            $display("FAIL one_side_join: req_ready=%b rready=%b, need 1/1", req_ready_o, rready_o);
        else passed++;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        total++;
        if (fire_cnt - start !== 1)
            $display("FAIL one_side_fires: fires=%0d, need 1", fire_cnt - start);
        else passed++;
    endtask

    task automatic test_async_reset();
        res_ready_i = 1'b0;
        set_pair(1'b1, ADDR_A, TAG_MIS, 1'b1, 1'b1, DATA_2);
        @(negedge clk);
        idle_inputs();
        total++;
        if (res_valid_o !== 1'b1)
            $display("FAIL areset_pre: valid=%b, need 1", res_valid_o);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (res_valid_o !== 1'b0 || res_class_o !== 2'd0 || res_evict_o !== 1'b0 || res_data_o !== '0)
            $display("FAIL areset_now: valid=%b class=%0d evict=%b data=%h, need 0 0 0 0",
                     res_valid_o, res_class_o, res_evict_o, res_data_o);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        total++;
        if (res_valid_o !== 1'b0)
            $display("FAIL areset_no_replay: valid=%b, need 0", res_valid_o);
        else passed++;
        @(negedge clk);
    endtask

`ifdef TAG_CHECK_STATS_EN
    task automatic test_stats();
        total++;
        if (stat_rhit_o !== 2'd0 || stat_evict_o !== 2'd0)
            $display("FAIL stat_reset: rhit=%0d evict=%0d, need 0 0", stat_rhit_o, stat_evict_o);
        else passed++;
        res_ready_i = 1'b1;
        set_pair(1'b0, ADDR_A, TAG_HIT, 1'b1, 1'b1, DATA_1);
        repeat (4) @(negedge clk);
        idle_inputs();
        total++;
        if (stat_rhit_o !== 2'd3 || stat_evict_o !== 2'd0 || stat_rmiss_o !== 2'd0)
            $display("FAIL stat_saturate: rhit=%0d evict=%0d rmiss=%0d, need 3 0 0",
                     stat_rhit_o, stat_evict_o, stat_rmiss_o);
        else passed++;
        set_pair(1'b0, ADDR_A, TAG_HIT, 1'b1, 1'b0, DATA_1);
        stat_clr_i = 1'b1;
        @(negedge clk);
        stat_clr_i = 1'b0;
        idle_inputs();
        total++;
        if (stat_rhit_o !== 2'd0)
            $display("FAIL stat_clr_priority: rhit=%0d, need 0", stat_rhit_o);
        else passed++;
        set_pair(1'b1, ADDR_A, TAG_MIS, 1'b1, 1'b1, DATA_2);
        @(negedge clk);
        idle_inputs();
        total++;
        if (stat_wmiss_o !== 2'd1 || stat_evict_o !== 2'd1 || stat_rhit_o !== 2'd0)
            $display("FAIL stat_wmiss: wmiss=%0d evict=%0d rhit=%0d, need 1 1 0",
                     stat_wmiss_o, stat_evict_o, stat_rhit_o);
        else passed++;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_read_hit();
        test_write_miss_evict();
        test_invalid_line();
        test_backpressure();
        test_one_side();
        test_async_reset();
`ifdef TAG_CHECK_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dram_tag_check.md
Name: dram_tag_check

Overview:
- Parametrised tag-check stage of the DRAM cache read path.
- Joins one request descriptor (from the request FIFO) with one AXI R beat carrying the stored tag and metadata.
- Classifies the pair as read/write hit/miss and flags dirty evictions.
- Presents one registered result, with a valid/ready handshake, to the reordering buffer; sustains one result per cycle under full throughput.

Parameters:
ADDR_W, 64, request address width
INDEX_W, 8, set-index bits directly above the offset
OFFSET_W, 0, line-offset bits at the address LSBs
DATA_W, 72, R-channel data width (data + ECC)
COUNT_W, 32, statistics counter width (used only with TAG_CHECK_STATS_EN)
Derived, not overridable: TAG_W = ADDR_W - INDEX_W - OFFSET_W (56 by default).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
req_valid_i  in  1  request descriptor valid
req_ready_o  out  1  request descriptor accepted
req_is_write_i  in  1  1 = write request, 0 = read request
req_addr_i  in  ADDR_W  request address
rvalid_i  in  1  AXI R beat valid
rready_o  out  1  AXI R beat accepted
rdata_i  in  DATA_W  line data
rtag_i  in  TAG_W  stored tag
rmeta_valid_i  in  1  stored line valid
rmeta_dirty_i  in  1  stored line dirty
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumed
res_class_o  out  2  0 RHIT, 1 RMISS, 2 WHIT, 3 WMISS
res_evict_o  out  1  miss on a valid, dirty line (writeback required)
res_data_o  out  DATA_W  captured rdata_i
res_addr_o  out  ADDR_W  captured req_addr_i
With TAG_CHECK_STATS_EN only:
stat_rhit_o, stat_rmiss_o, stat_whit_o, stat_wmiss_o, stat_evict_o  out  COUNT_W  event counters
stat_clr_i  in  1  synchronous clear of all counters

Behaviour:
- Reset (rst_n low, asynchronous): res_valid_o=0; res_class_o, res_evict_o, res_data_o, res_addr_o = 0; counters = 0. On release the slot is EMPTY.
- Reset mid-transfer: any held result is dropped. Nothing is replayed.
- Slot states: EMPTY, FULL. slot_free = EMPTY || (FULL && res_ready_i).
- Join handshake: req_ready_o = rvalid_i && slot_free; rready_o = req_valid_i && slot_free.
- Fire = req_valid_i && rvalid_i && slot_free. On fire both sides are consumed in the same cycle; one side is never consumed alone.
- Neither ready depends on its own valid.
- On fire, the result registers load on the next clk edge, giving a latency of 1 cycle.
- Slot transitions on fire:
  - EMPTY -> FULL.
  - FULL with res_ready_i -> stays FULL with the new contents (back-to-back, no bubble).
- FULL, res_ready_i=1, no fire -> EMPTY; res_valid_o drops on the next edge.
- FULL, res_ready_i=0 -> outputs held stable and both readys are 0 (AXI stability rule).
- Hit rule: hit = rmeta_valid_i && (req_addr_i[ADDR_W-1:INDEX_W+OFFSET_W] == rtag_i). An invalid line is always a miss, even on a tag match.
- Class = {req_is_write_i, !hit}.
- res_evict_o = !hit && rmeta_valid_i && rmeta_dirty_i. It is never set on a hit.
- Result data captures rdata_i unconditionally. Other classes' data is not zeroed; class alone identifies the result.
- Outputs are registers only; no combinational path from inputs to res_*.

Optional Feature:
TAG_CHECK_STATS_EN
- Defined: five saturating counters, each incrementing by 1 on the fire that produces the matching class, and stat_evict_o on fire with evict.
  - Counters saturate at 2^COUNT_W-1 and do not wrap.
  - stat_clr_i has priority over an increment in the same cycle.
  - Counters are reset by rst_n.
- Undefined: the stat ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then read addr 0x0000_1234_5678_9A00, rtag 0x00_0012_3456_789A, valid=1 -> one cycle after fire: res_valid_o=1, class=0 (RHIT), evict=0, data/addr echoed.
- Write, same addr, rtag 0x00_0012_3456_7890, valid=1, dirty=1 -> class=3 (WMISS), evict=1.
- Read with matching tag, meta valid=0, dirty=1 -> class=1 (RMISS), evict=0.
- res_ready_i=0 for 5 cycles while both sides are valid -> req_ready_o=rready_o=0 and outputs stable; raise res_ready_i -> next pair accepted the same cycle and replaces the old result with no bubble.
- Only rvalid_i=1 for 3 cycles, then req_valid_i=1 -> no readys until both are valid; exactly one fire.
- Assert rst_n=0 mid-clock while FULL -> res_valid_o=0 immediately. With TAG_CHECK_STATS_EN: 4 RHIT fires (COUNT_W=2) -> stat_rhit_o saturates at 3; stat_clr_i together with a fire -> 0.
